muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative 32-bit unsigned multiply/divide unit sitting beside the ALU in the execute stage. It consumes the two register-file read operands and produces a result on a dedicated write-back port that is muxed into the register-file write path. While it works it stalls the core, so the single-cycle datapath can host multi-cycle MUL/DIV instructions.

Parameters:
XLEN, 32, operand/result width
ADDR_W, 5, register address width (32 registers)
CNT_W, 6, iteration counter width; must hold values 0..XLEN

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
start  input  1  decoder requests a MUL/DIV op this cycle
op  input  2  00 MUL (low product), 01 MULHU (high product), 10 DIVU (quotient), 11 REMU (remainder)
src_a  input  XLEN  operand A, register read data 1
src_b  input  XLEN  operand B, register read data 2
dest_addr  input  ADDR_W  destination register
stall  output  1  hold PC and all architectural state this cycle
busy  output  1  unit is not IDLE
wb_en  output  1  one-cycle write-back strobe to register file
wb_addr  output  ADDR_W  write-back register address
wb_data  output  XLEN  write-back data

Behaviour:
- Interface: clock clk; reset reset, synchronous, active-high. All state updates happen on posedge clk.
- FSM states are IDLE, RUN, DONE.
- IDLE: if start=1, latch op, src_a, src_b and dest_addr, clear the counter and go to RUN. Otherwise stay in IDLE.
- RUN: perform one iteration per cycle and increment the counter. After XLEN iterations (counter==XLEN-1 at the clock edge), go to DONE.
- DONE: wb_en=1 for exactly this one cycle, with wb_addr and wb_data valid. Go to IDLE on the next edge.
- Latency: start is sampled at edge 0, RUN covers cycles 1..32, and DONE is cycle 33. wb_en is high during cycle 33 for XLEN=32.
- stall = (state==IDLE && start) || state==RUN. stall is low in DONE, so the core retires the instruction in the same cycle as write-back.
- busy = (state != IDLE).
- start while busy is ignored. Operands are never re-latched mid-operation.
- Multiply: shift-add over a 2*XLEN accumulator. Each iteration examines multiplier bit LSB-first. MUL returns product[XLEN-1:0]; MULHU returns product[2*XLEN-1:XLEN]. Arithmetic is unsigned and modulo 2^(2*XLEN).
- Divide: restoring division. Each iteration shifts {rem, quot} left by 1 and subtracts the divisor using an XLEN+1-bit difference. If the difference is non-negative, keep it and set the quotient LSB.
- Divide by zero: DIVU returns all ones (0xFFFFFFFF); REMU returns src_a. No exception is raised, and latency is the same as a normal divide.
- dest_addr==0: the op executes and stalls normally, but wb_en stays 0 in DONE.
- wb_addr and wb_data hold their last values outside DONE. Only wb_en qualifies them.
- Reset values: state=IDLE, counter=0, all operand/accumulator registers 0, wb_en=0, wb_addr=0, wb_data=0, busy=0. stall follows its combinational equation (0 unless start asserted).
- Reset mid-operation (RUN or DONE): abort the operation, discard the result, and suppress wb_en, returning to IDLE on the next edge.

Decomposition:
- Shared package muldiv_pkg holds:
  - XLEN default
  - op encodings OP_MUL, OP_MULHU, OP_DIVU, OP_REMU
  - state enum IDLE/RUN/DONE
  - 2-bit op typedef
- One sub-module, muldiv_step: purely combinational single-iteration datapath (one shift-add step or one restoring-subtract step, selected by op class).
- muldiv_unit owns the FSM, counter and registers, and instantiates muldiv_step once.

Test Plan:
- MUL, src_a=7, src_b=6, dest=3 -> stall high in cycles 0..32; wb_en=1 in cycle 33 with wb_addr=3, wb_data=42; busy=0 in cycle 34.
- MULHU, 0xFFFFFFFF × 0xFFFFFFFF -> wb_data=0xFFFFFFFE. The same operands with MUL -> wb_data=0x00000001.
- DIVU 100/7 -> wb_data=14; REMU 100/7 -> wb_data=2; DIVU 0x80000000/1 -> wb_data=0x80000000.
- DIVU 55/0 -> wb_data=0xFFFFFFFF; REMU 55/0 -> wb_data=55; both with 33-cycle latency.
- start pulsed with new operands at cycle 10 of a running MUL 7×6 -> ignored, result still 42. A separate MUL with dest=0 -> full stall sequence, wb_en never asserted.
- reset asserted in cycle 15 of a DIVU -> cycle 16: busy=0, stall=0, wb_en=0, and no write-back ever appears. A fresh MUL 3×5 afterwards -> wb_data=15.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 6;

  typedef logic [1:0] op_t;

  localparam op_t OP_MUL   = 2'b00;
  localparam op_t OP_MULHU = 2'b01;
  localparam op_t OP_DIVU  = 2'b10;
  localparam op_t OP_REMU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_div(op_t op);
    return op[1];
  endfunction

  // MULHU and REMU live in the upper half of the accumulator.
  function automatic logic [XLEN-1:0] res_sel(
    op_t                  op,
    logic [2*XLEN-1:0]    acc
  );
    logic [XLEN-1:0] r;
    unique case (op)
      OP_MUL,
      OP_DIVU:  r = acc[XLEN-1:0];
      OP_MULHU,
      OP_REMU:  r = acc[2*XLEN-1:XLEN];
      default:  r = acc[XLEN-1:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/write-back bundle between the execute stage and the mul/div unit.
interface muldiv_if;
  import muldiv_pkg::*;

  logic              start;
  op_t               op;
  logic [XLEN-1:0]   src_a;
  logic [XLEN-1:0]   src_b;
  logic [ADDR_W-1:0] dest_addr;
  logic              stall;
  logic              busy;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [XLEN-1:0]   wb_data;

  modport master (
    output start, op, src_a, src_b, dest_addr,
    input  stall, busy, wb_en, wb_addr, wb_data
  );

  modport slave (
    input  start, op, src_a, src_b, dest_addr,
    output stall, busy, wb_en, wb_addr, wb_data
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration: shift-add multiply step or restoring divide step.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic              div_i,
  input  logic [XLEN-1:0]   opd_i,
  input  logic [2*XLEN-1:0] acc_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   rsh;
  logic [XLEN:0]   diff;

  always_comb begin
    hi   = acc_i[2*XLEN-1:XLEN];
    lo   = acc_i[XLEN-1:0];
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, opd_i} : '0);
    rsh  = {hi, lo[XLEN-1]};
    diff = rsh - {1'b0, opd_i};
    if (div_i) begin
      // Negative difference restores the shifted remainder.
      if (diff[XLEN])
        acc_o = {rsh[XLEN-1:0], lo[XLEN-2:0], 1'b0};
      else
        acc_o = {diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
    end else begin
      acc_o = {sum, lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit unsigned MUL/MULHU/DIVU/REMU unit; stalls the core
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  op_t               op_q, op_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [XLEN-1:0]   opd_q, opd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic [2*XLEN-1:0] step_acc;

  muldiv_step u_step (
    .div_i (is_div(op_q)),
    .opd_i (opd_q),
    .acc_i (acc_q),
    .acc_o (step_acc)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    dest_d    = dest_q;
    opd_d     = opd_q;
    acc_d     = acc_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          dest_d  = bus.dest_addr;
          cnt_d   = '0;
          // opd is the multiplicand or divisor; acc low half
          // holds the multiplier or dividend.
          opd_d   = is_div(bus.op) ? bus.src_b : bus.src_a;
          acc_d   = {{XLEN{1'b0}},
                     is_div(bus.op) ? bus.src_a : bus.src_b};
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN-1)) begin
          state_d   = DONE;
          wb_addr_d = dest_q;
          wb_data_d = res_sel(op_q, step_acc);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MUL;
      dest_q    <= '0;
      opd_q     <= '0;
      acc_q     <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      dest_q    <= dest_d;
      opd_q     <= opd_d;
      acc_q     <= acc_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign bus.stall   = (state_q == IDLE && bus.start) ||
                       (state_q == RUN);
  assign bus.busy    = (state_q != IDLE);
  assign bus.wb_en   = (state_q == DONE) && (dest_q != '0);
  assign bus.wb_addr = wb_addr_q;
  assign bus.wb_data = wb_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: latency, results, div-by-zero,
// ignored start, x0 destination and mid-operation reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  wb_t  sb[$];

  muldiv_if bus();

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(
    op_t op, logic [31:0] a, logic [31:0] b
  );
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      OP_MUL:   return p[31:0];
      OP_MULHU: return p[63:32];
      OP_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default:  return (b == 0) ? a : a % b;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset && bus.wb_en === 1'b1) begin
      wb_t got;
      wb_t exp;
      got = {bus.wb_addr, bus.wb_data};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected: addr=%0d data=%h, none expected",
                 bus.wb_addr, bus.wb_data);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          bad++;
          $display("FAIL wb_result: got addr=%0d data=%h, want addr=%0d data=%h",
                   got.addr, got.data, exp.addr, exp.data);
        end
      end
    end
  end

  task automatic run_op(
    input op_t         op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  d,
    input int          pulse
  );
    logic [31:0] exp;
    int          stall_bad;
    exp       = model(op, a, b);
    stall_bad = 0;
    for (int c = 0; c <= 34; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 0) begin
        bus.start     = 1'b1;
        bus.op        = op;
        bus.src_a     = a;
        bus.src_b     = b;
        bus.dest_addr = d;
        if (d != 0) sb.push_back({d, exp});
      end else if (c == pulse) begin
        bus.start     = 1'b1;
        bus.op        = OP_DIVU;
        bus.src_a     = 32'd99;
        bus.src_b     = 32'd11;
        bus.dest_addr = 5'd9;
      end
      #1;
      if (c <= 32 && bus.stall !== 1'b1) stall_bad++;
      if (c == 33) begin
        total++;
        if (bus.wb_en !== (d != 0)) begin
          bad++;
          $display("FAIL wb_en_c33: got %b want %b", bus.wb_en, d != 0);
        end
        total++;
        if (bus.stall !== 1'b0 || bus.busy !== 1'b1) begin
          bad++;
          $display("FAIL done_flags: stall=%b busy=%b want stall=0 busy=1",
                   bus.stall, bus.busy);
        end
      end
      if (c == 34) begin
        total++;
        if (bus.busy !== 1'b0) begin
          bad++;
          $display("FAIL busy_c34: got %b want 0", bus.busy);
        end
        if (d != 0) begin
          total++;
          if (bus.wb_data !== exp || bus.wb_addr !== d) begin
            bad++;
            $display("FAIL wb_hold: got %0d/%h want %0d/%h",
                     bus.wb_addr, bus.wb_data, d, exp);
          end
        end
      end
    end
    total++;
    if (stall_bad != 0) begin
      bad++;
      $display("FAIL stall_run: %0d cycles low, want 0", stall_bad);
    end
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.op        = OP_MUL;
    bus.src_a     = '0;
    bus.src_b     = '0;
    bus.dest_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.wb_en !== 1'b0 || bus.stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: busy=%b wb_en=%b stall=%b want 0 0 0",
               bus.busy, bus.wb_en, bus.stall);
    end
    total++;
    if (bus.wb_addr !== '0 || bus.wb_data !== '0) begin
      bad++;
      $display("FAIL reset_wb: addr=%0d data=%h want 0 0",
               bus.wb_addr, bus.wb_data);
    end
    bus.start = 1'b1;
    #1;
    total++;
    if (bus.stall !== 1'b1) begin
      bad++;
      $display("FAIL reset_stall_start: got %b want 1", bus.stall);
    end
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mul();
    run_op(OP_MUL,   32'd7,         32'd6,         5'd3, -1);
    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, -1);
    run_op(OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, -1);
  endtask

  task automatic test_div();
    run_op(OP_DIVU, 32'd100,       32'd7, 5'd6,  -1);
    run_op(OP_REMU, 32'd100,       32'd7, 5'd7,  -1);
    run_op(OP_DIVU, 32'h8000_0000, 32'd1, 5'd8,  -1);
    run_op(OP_DIVU, 32'd55,        32'd0, 5'd10, -1);
    run_op(OP_REMU, 32'd55,        32'd0, 5'd11, -1);
  endtask

  task automatic test_ignore_start();
    run_op(OP_MUL, 32'd7, 32'd6, 5'd3, 10);
  endtask

  task automatic test_dest_zero();
    run_op(OP_MUL, 32'd9, 32'd9, 5'd0, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      op_t         op;
      logic [31:0] a;
      logic [31:0] b;
      op = op_t'($urandom_range(3, 0));
      a  = $urandom;
      b  = (i == 0) ? 32'd0 : $urandom >> $urandom_range(31, 0);
      run_op(op, a, b, 5'(i + 12), -1);
    end
  endtask

  task automatic test_mid_reset();
    int wb_seen;
    for (int c = 0; c <= 15; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 0) begin
        bus.start     = 1'b1;
        bus.op        = OP_DIVU;
        bus.src_a     = 32'd1000;
        bus.src_b     = 32'd3;
        bus.dest_addr = 5'd20;
      end
      if (c == 15) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.wb_en !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_c16: busy=%b stall=%b wb_en=%b want 0 0 0",
               bus.busy, bus.stall, bus.wb_en);
    end
    wb_seen = 0;
    repeat (30) begin
      @(negedge clk);
      #1;
      if (bus.wb_en !== 1'b0) wb_seen++;
    end
    total++;
    if (wb_seen != 0) begin
      bad++;
      $display("FAIL mid_reset_wb: %0d strobes seen, want 0", wb_seen);
    end
    run_op(OP_MUL, 32'd3, 32'd5, 5'd21, -1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_mul();
    test_div();
    test_ignore_start();
    test_dest_zero();
    test_random();
    test_mid_reset();
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d results outstanding, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
